// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-time game controller:
// the state encoding and the BCD nibble width.
package reaction_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_REACTION  = 3'd2,
    ST_SCORE     = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

endpackage

// File: rtl/reaction_ctrl_bcd_counter.sv
// Packed-BCD up-counter holding the running reaction time.
// It saturates at all-9s; clr takes priority over inc.
module bcd_counter
  import reaction_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       inc,
  input  logic                       clr,
  output logic [NIBBLE_W*DIGITS-1:0] value,
  output logic                       all_nines
);

  localparam int W = NIBBLE_W * DIGITS;
  localparam logic [W-1:0] NINES = {DIGITS{4'h9}};

  logic [W-1:0] r_value;
  logic [W-1:0] w_next;
  logic         w_carry;

  // Ripple the +1 through the digits, wrapping each 9 to 0.
  always_comb begin
    w_next  = r_value;
    w_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_carry) begin
        if (r_value[i*NIBBLE_W +: NIBBLE_W] == 4'd9) begin
          w_next[i*NIBBLE_W +: NIBBLE_W] = 4'd0;
        end else begin
          w_next[i*NIBBLE_W +: NIBBLE_W] = r_value[i*NIBBLE_W +: NIBBLE_W] + 4'd1;
          w_carry = 1'b0;
        end
      end else begin
        w_next[i*NIBBLE_W +: NIBBLE_W] = r_value[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_value <= '0;
    end else if (clr) begin
      r_value <= '0;
    end else if (inc && !all_nines) begin
      r_value <= w_next;
    end else begin
      r_value <= r_value;
    end
  end

  assign all_nines = (r_value == NINES);
  assign value     = r_value;

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-time game controller: countdown, timed reaction window,
// false-start detection and best-score tracking in packed BCD.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int CLK_DIV  = 50000,
  parameter int DIGITS   = 4,
  parameter int CD_TICKS = 2000
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       react,
  input  logic                       clear,
  output logic [2:0]                 state,
  output logic                       go_led,
  output logic [NIBBLE_W*DIGITS-1:0] time_bcd,
  output logic [NIBBLE_W*DIGITS-1:0] best_bcd,
  output logic                       new_best,
  output logic                       false_start
);

  localparam int W       = NIBBLE_W * DIGITS;
  localparam int PRESC_W = $clog2(CLK_DIV);
  localparam int CD_W    = $clog2(CD_TICKS + 1);
  localparam logic [W-1:0] NINES = {DIGITS{4'h9}};

  state_e             r_state;
  logic [PRESC_W-1:0] r_presc;
  logic [CD_W-1:0]    r_cd_cnt;
  logic               r_timed_out;
  logic               r_score_first;
  logic [W-1:0]       r_best;
  logic               r_new_best;
  logic               r_go_led;
  logic               r_false_start;

  logic               w_tick;
  logic               w_inc;
  logic               w_clr;
  logic [W-1:0]       w_time;
  logic               w_all_nines;

  assign w_tick = (r_presc == PRESC_W'(CLK_DIV - 1));
  // A tick coinciding with react (or clear) is not counted.
  assign w_inc  = (r_state == ST_REACTION) && w_tick && !react && !clear;
  assign w_clr  = (r_state == ST_IDLE) && start && !clear;

  bcd_counter #(
    .DIGITS(DIGITS)
  ) u_time (
    .clock    (clock),
    .reset_n  (reset_n),
    .inc      (w_inc),
    .clr      (w_clr),
    .value    (w_time),
    .all_nines(w_all_nines)
  );

  // Game FSM with prescaler, countdown, best-score update and registered flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_presc       <= '0;
      r_cd_cnt      <= '0;
      r_timed_out   <= 1'b0;
      r_score_first <= 1'b0;
      r_best        <= NINES;
      r_new_best    <= 1'b0;
      r_go_led      <= 1'b0;
      r_false_start <= 1'b0;
    end else begin
      r_new_best <= 1'b0;
      r_presc    <= w_tick ? '0 : r_presc + PRESC_W'(1);
      if (clear) begin
        if (r_state != ST_IDLE) begin
          r_state <= ST_IDLE;
          r_presc <= '0;
        end
        r_score_first <= 1'b0;
        r_go_led      <= 1'b0;
        r_false_start <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state     <= ST_COUNTDOWN;
              r_presc     <= '0;
              r_cd_cnt    <= '0;
              r_timed_out <= 1'b0;
            end
          end
          ST_COUNTDOWN: begin
            // react is checked first so it beats the final tick
            if (react) begin
              r_state       <= ST_FAULT;
              r_presc       <= '0;
              r_false_start <= 1'b1;
            end else if (w_tick) begin
              if (r_cd_cnt == CD_W'(CD_TICKS - 1)) begin
                r_state  <= ST_REACTION;
                r_presc  <= '0;
                r_go_led <= 1'b1;
              end else begin
                r_cd_cnt <= r_cd_cnt + CD_W'(1);
              end
            end
          end
          ST_REACTION: begin
            if (react || w_all_nines) begin
              r_state       <= ST_SCORE;
              r_presc       <= '0;
              r_go_led      <= 1'b0;
              r_score_first <= 1'b1;
              r_timed_out   <= !react;
            end
          end
          ST_SCORE: begin
            if (r_score_first) begin
              r_score_first <= 1'b0;
              if (!r_timed_out && (w_time < r_best)) begin
                r_best     <= w_time;
                r_new_best <= 1'b1;
              end
            end
          end
          ST_FAULT: begin
            r_false_start <= 1'b1;
          end
          default: begin
            r_state       <= ST_IDLE;
            r_presc       <= '0;
            r_go_led      <= 1'b0;
            r_false_start <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state       = r_state;
  assign go_led      = r_go_led;
  assign time_bcd    = w_time;
  assign best_bcd    = r_best;
  assign new_best    = r_new_best;
  assign false_start = r_false_start;

endmodule

// File: doc/reaction_ctrl.md
REACTION_CTRL -- requirements
Module: reaction_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 50000, clock cycles per 1 ms tick; legal range >= 2.
REQ-002 Parameter DIGITS, default 4, BCD digits in reaction time and best score; legal range 1..6.
REQ-003 Parameter CD_TICKS, default 2000, countdown length in ticks; legal range >= 1.
REQ-004 Port clock, input, 1 bit: the single clock, rising edge.
REQ-005 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: debounced, active-high, synchronous to clock; requests a run.
REQ-007 Port react, input, 1 bit: debounced, active-high player button.
REQ-008 Port clear, input, 1 bit: active-high; returns the block to IDLE.
REQ-009 Port state, output, 3 bits: current state code.
REQ-010 Port go_led, output, 1 bit: high only in REACTION.
REQ-011 Port time_bcd, output, 4*DIGITS bits: reaction time in ms, packed BCD, least-significant digit in the low nibble.
REQ-012 Port best_bcd, output, 4*DIGITS bits: best (lowest) valid reaction time, packed BCD.
REQ-013 Port new_best, output, 1 bit: one-cycle pulse when best_bcd is updated.
REQ-014 Port false_start, output, 1 bit: high in FAULT.

Function
REQ-015 The block SHALL implement five states with fixed codes: IDLE=0, COUNTDOWN=1, REACTION=2, SCORE=3, FAULT=4.
REQ-016 All transitions SHALL take effect on the clock edge that samples the qualifying input (1-cycle latency).
REQ-017 Prescaler: counts 0..CLK_DIV-1, wraps to 0, and asserts tick for one cycle at CLK_DIV-1; it clears on every state change.
REQ-018 IDLE: start=1 and clear=0 -> COUNTDOWN; time_bcd cleared to 0 on the same edge.
REQ-019 COUNTDOWN: counts ticks; react=1 -> FAULT; on the tick that completes CD_TICKS -> REACTION.
REQ-020 COUNTDOWN: if react and the final tick coincide, FAULT wins.
REQ-021 COUNTDOWN: react already held on entry counts as a false start.
REQ-022 REACTION: time_bcd increments by 1 per tick with BCD carry (digit 9 -> 0, carry into the next digit).
REQ-023 REACTION: react=1 -> SCORE with time_bcd frozen; a tick in the same cycle is not counted.
REQ-024 REACTION: when time_bcd reaches all-9s it saturates, the state -> SCORE, and the run is marked timed-out.
REQ-025 SCORE, first cycle only: if not timed-out and time_bcd < best_bcd (unsigned compare of the packed vectors), best_bcd <= time_bcd and new_best=1 for exactly 1 cycle.
REQ-026 SCORE: an equal time SHALL NOT update best_bcd or pulse new_best.
REQ-027 SCORE and FAULT exit only on clear=1 -> IDLE.
REQ-028 clear=1 in any state -> IDLE; clear has priority over start, react and tick.
REQ-029 start SHALL be ignored outside IDLE.
REQ-030 Returning to IDLE SHALL NOT modify best_bcd; time_bcd holds its last value.

Reset
REQ-031 reset_n=0 asynchronously forces: state=IDLE; time_bcd=0; best_bcd=all-9s; new_best=0; false_start=0; go_led=0; prescaler, countdown counter and timed-out flag cleared.
REQ-032 Reset asserted mid-run aborts the run without updating best_bcd.
REQ-033 The block leaves reset on the first clock edge after reset_n rises.

Structure
REQ-034 Package reaction_pkg SHALL hold the state codes and the BCD nibble width constant.
REQ-035 Sub-module bcd_counter (parameter DIGITS; inputs inc, clr; outputs value, all_nines) SHALL implement time_bcd.
REQ-036 best_bcd and the compare logic SHALL reside in reaction_ctrl.

Verification (bench parameters: CLK_DIV=4, DIGITS=2, CD_TICKS=3)
REQ-037 Release reset -> state=0, best_bcd=8'h99, time_bcd=8'h00, all flags 0.
REQ-038 Pulse start, no react for 3 ticks -> REACTION with go_led=1; react after 5 ticks -> SCORE, time_bcd=8'h05, best_bcd=8'h05, new_best high for 1 cycle.
REQ-039 clear, then a second run with react after 7 ticks -> time_bcd=8'h07, best_bcd stays 8'h05, new_best stays 0.
REQ-040 Run with react asserted during COUNTDOWN -> state=4, false_start=1, best unchanged; clear -> state=0, false_start=0.
REQ-041 Run with no react in REACTION -> time_bcd=8'h99 after 99 ticks, state=3, best unchanged; clear and start asserted together in SCORE -> IDLE.
REQ-042 reset_n pulsed low mid-REACTION -> immediate state=0, best_bcd=8'h99, go_led=0 without waiting for a clock edge.
